axi_hp_responder: RTL and testbench
===================================

// Module: axi_hp_responder
// PURPOSE
// AXI3 slave (HP-port profile: 32-bit data, 6-bit IDs, 4-bit len) backed by on-chip RAM.
// Answers the stream mover's DDR burst traffic, either as a fabric-side sample buffer or as the
// bench target for it. Serves one transaction at a time; write/read arbitration is round-robin.
// PARAMETERS
// BASE_ADDR  32'h1F00_0000  byte address of word 0; region size = 4*2**MEM_AW bytes
// MEM_AW     12             RAM word-address width (4096 x 32 bit)
// PORTS
// clk          in   1   single clock for all logic
// rst_n        in   1   asynchronous active-low reset
// AXI_aw*      in/out -  awaddr[31:0] awid[5:0] awlen[3:0] awsize[2:0] awburst[1:0] awvalid in; awready out
// AXI_w*       in/out -  wdata[31:0] wstrb[3:0] wid[5:0] wlast wvalid in; wready out
// AXI_b*       in/out -  bid[5:0] bresp[1:0] bvalid out; bready in
// AXI_ar*      in/out -  araddr[31:0] arid[5:0] arlen[3:0] arsize[2:0] arburst[1:0] arvalid in; arready out
// AXI_r*       in/out -  rdata[31:0] rid[5:0] rresp[1:0] rlast rvalid out; rready in
// (awlock/awcache/awprot/awqos and the ar* equivalents are accepted and ignored)
// BEHAVIOUR
// - Reset: all ready/valid outputs 0, bresp/rresp=OKAY, bid/rid/rdata=0, FSM=IDLE, rr-flag favours write.
// - FSM: IDLE -> WDATA -> WRESP -> IDLE ; IDLE -> RDATA -> IDLE.
// - IDLE: awready/arready are registered and pulse for one cycle on grant. Both valids present:
//   grant the side not granted last. A single valid is granted immediately.
// - Address check at grant: size!=3'b010 or burst==WRAP -> SLVERR. Any beat outside
//   [BASE_ADDR, BASE_ADDR+4*2**MEM_AW) -> DECERR (whole burst checked: addr+4*len for INCR).
//   On error, beats are still fully handshaken; no RAM write; rdata=0.
// - Word index = (addr-BASE_ADDR)>>2; INCR +1 per beat; FIXED holds it. No 4 KB check.
// - WDATA: wready=1 continuously; each wvalid&wready writes the byte lanes set in wstrb.
//   wid!=awid on any beat -> final bresp=SLVERR (data still written). Beat count is len+1;
//   wlast on the wrong beat -> SLVERR. The burst ends at count, regardless of wlast.
// - WRESP: bvalid=1 with bid=awid and the sticky error resp; hold until bready; then IDLE.
//   Write latency: 1 cycle from the last W beat to bvalid.
// - RDATA: RAM has 1-cycle read latency; first rvalid 2 cycles after the ar handshake.
//   A single output register plus a 1-entry skid sustains 1 beat/cycle under rready=1.
//   rvalid/rdata/rlast stay stable while rready=0. rlast on beat len+1; IDLE after it is accepted.
// - Simultaneous aw+ar in the cycle the previous transaction ends: arbitration happens the next
//   cycle in IDLE (1 dead cycle between transactions).
// - rst_n low mid-burst: immediate return to IDLE; RAM contents are kept; partial burst is
//   not responded to.
// CONFIGURATION
// AXI_RSP_STALL_EN defined: a 16-bit LFSR (x^16+x^14+x^13+x^11+1, seed 16'hACE1) masks
//   wready, and the issue of a new rvalid beat, when lfsr[1:0]==0 (~25% stall).
//   awready/arready grant is delayed likewise. The LFSR advances every cycle.
// Undefined: no stalls; timing is exactly as stated above.
// STRUCTURE
// Package axi_hp_pkg: RESP_OKAY/EXOKAY/SLVERR/DECERR, BURST_FIXED/INCR/WRAP, state encodings,
//   ID/len widths.
// Sub-module axi_hp_rsp_ram: single-port 2**MEM_AW x 32 RAM with 4 byte enables, sync read.
// Top holds the FSM, arbiter, address/beat counters, error tracking, read skid, and the optional LFSR.
// TESTING
// 1 INCR write awaddr=BASE, len=3, wdata 1..4, wstrb=F -> bresp OKAY, bid=awid; then INCR read
//   len=3 -> rdata 1,2,3,4, rlast on 4th beat, back-to-back beats with rready=1.
// 2 FIXED write len=1 to BASE+8, data A then B, then read BASE+8 -> B. Partial wstrb=4'b0011
//   over 32'hFFFF_FFFF -> 32'h0000_FFFF.
// 3 awaddr=BASE+4*(2**MEM_AW)-4, INCR len=1 -> all beats accepted, bresp DECERR, RAM unchanged.
//   arsize=3'b001 -> rresp SLVERR, rdata 0.
// 4 aw and ar valid in the same cycle, twice -> grants write, read, write, read (round-robin).
// 5 rready toggled 1010... during len=15 read -> 16 beats in order, no drop or duplicate.
//   Run with AXI_RSP_STALL_EN defined -> same data, with stalls.
// 6 rst_n pulsed low in mid-write burst -> outputs at reset values; next read returns the beats
//   written before the reset.

Source files
------------

// File: rtl/axi_hp_pkg.sv
// Shared constants and types for the HP-port AXI3 responder.
package axi_hp_pkg;

  localparam int unsigned ID_W  = 6;
  localparam int unsigned LEN_W = 4;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  typedef enum logic [1:0] {
    StIdle,
    StWdata,
    StWresp,
    StRdata
  } state_e;

endpackage

// File: rtl/axi_hp_rsp_ram.sv
// Single-port word RAM with byte enables and one-cycle synchronous read.
module axi_hp_rsp_ram #(
  parameter int unsigned MEM_AW = 12
) (
  input  logic              clk,
  input  logic              i_en,
  input  logic              i_we,
  input  logic [3:0]        i_be,
  input  logic [MEM_AW-1:0] i_addr,
  input  logic [31:0]       i_wdata,
  output logic [31:0]       o_rdata
);

  logic [31:0] r_mem [0:(2**MEM_AW)-1];

  // Byte-lane writes, or a registered read when not writing.
  always_ff @(posedge clk) begin
    if (i_en) begin
      if (i_we) begin
        for (int b = 0; b < 4; b++) begin
          if (i_be[b]) r_mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
        end
      end else begin
        o_rdata <= r_mem[i_addr];
      end
    end
  end

endmodule

// File: rtl/axi_hp_responder.sv
// AXI3 HP-profile slave backed by on-chip RAM; one transaction at a time, round-robin aw/ar.
// Optional macro AXI_RSP_STALL_EN: LFSR-driven random stalls on grant, wready and read issue.
module axi_hp_responder
  import axi_hp_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h1F00_0000,
  parameter int unsigned MEM_AW    = 12
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      AXI_awaddr,
  input  logic [ID_W-1:0]  AXI_awid,
  input  logic [LEN_W-1:0] AXI_awlen,
  input  logic [2:0]       AXI_awsize,
  input  logic [1:0]       AXI_awburst,
  input  logic             AXI_awvalid,
  output logic             AXI_awready,
  input  logic [31:0]      AXI_wdata,
  input  logic [3:0]       AXI_wstrb,
  input  logic [ID_W-1:0]  AXI_wid,
  input  logic             AXI_wlast,
  input  logic             AXI_wvalid,
  output logic             AXI_wready,
  output logic [ID_W-1:0]  AXI_bid,
  output logic [1:0]       AXI_bresp,
  output logic             AXI_bvalid,
  input  logic             AXI_bready,
  input  logic [31:0]      AXI_araddr,
  input  logic [ID_W-1:0]  AXI_arid,
  input  logic [LEN_W-1:0] AXI_arlen,
  input  logic [2:0]       AXI_arsize,
  input  logic [1:0]       AXI_arburst,
  input  logic             AXI_arvalid,
  output logic             AXI_arready,
  output logic [31:0]      AXI_rdata,
  output logic [ID_W-1:0]  AXI_rid,
  output logic [1:0]       AXI_rresp,
  output logic             AXI_rlast,
  output logic             AXI_rvalid,
  input  logic             AXI_rready
);

  localparam logic [32:0] REGION = 33'd4 << MEM_AW;

  function automatic logic [1:0] addr_chk(input logic [31:0] addr, input logic [LEN_W-1:0] len,
                                          input logic [2:0] size, input logic [1:0] burst);
    logic [32:0] off;
    logic [32:0] last;
    off  = {1'b0, addr} - {1'b0, BASE_ADDR};
    last = off + ((burst == BURST_INCR) ? {27'd0, len, 2'b00} : 33'd0);
    if (size != 3'b010 || burst == BURST_WRAP) return RESP_SLVERR;
    if (addr < BASE_ADDR || last >= REGION)    return RESP_DECERR;
    return RESP_OKAY;
  endfunction

  function automatic logic [MEM_AW-1:0] idx_of(input logic [31:0] addr);
    return MEM_AW'((addr - BASE_ADDR) >> 2);
  endfunction

  state_e             r_state, w_state_nxt;
  logic               r_last_wr, r_awready, r_arready;
  logic [ID_W-1:0]    r_id;
  logic [LEN_W-1:0]   r_len, r_beat;
  logic [1:0]         r_burst, r_resp;
  logic [MEM_AW-1:0]  r_idx;
  logic               r_acc_err, r_issue_done;
  logic               r_pend, r_pend_last;
  logic               r_rvalid, r_rlast, r_skid_v, r_skid_last;
  logic [31:0]        r_rdata, r_skid_data;
  logic               w_grant_wr, w_grant_rd, w_wready, w_wbeat, w_issue, w_pop, w_stall;
  logic [1:0]         w_occ, w_aw_chk, w_ar_chk;
  logic [31:0]        w_ram_rdata, w_pend_data;

`ifdef AXI_RSP_STALL_EN
  logic [15:0] r_lfsr;

  // Free-running LFSR, x^16+x^14+x^13+x^11+1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_lfsr <= 16'hACE1;
    else        r_lfsr <= {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
  end
  assign w_stall = (r_lfsr[1:0] == 2'b00);
`else
  assign w_stall = 1'b0;
`endif

  assign w_aw_chk = addr_chk(AXI_awaddr, AXI_awlen, AXI_awsize, AXI_awburst);
  assign w_ar_chk = addr_chk(AXI_araddr, AXI_arlen, AXI_arsize, AXI_arburst);

  assign w_wready    = (r_state == StWdata) && !w_stall;
  assign w_wbeat     = w_wready && AXI_wvalid;
  assign w_pop       = r_rvalid && AXI_rready;
  assign w_occ       = {1'b0, r_rvalid} + {1'b0, r_skid_v} + {1'b0, r_pend};
  // Keep at most two beats in flight so the output register plus skid never overflow.
  assign w_issue     = (r_state == StRdata) && !r_issue_done && !w_stall &&
                       ((w_occ < 2'd2) || w_pop);
  assign w_pend_data = r_acc_err ? 32'h0 : w_ram_rdata;

  // Next-state logic and arbitration; the side not granted last wins a tie.
  always_comb begin
    w_state_nxt = r_state;
    w_grant_wr  = 1'b0;
    w_grant_rd  = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (!w_stall) begin
          if (AXI_awvalid && (!AXI_arvalid || !r_last_wr)) begin
            w_grant_wr  = 1'b1;
            w_state_nxt = StWdata;
          end else if (AXI_arvalid) begin
            w_grant_rd  = 1'b1;
            w_state_nxt = StRdata;
          end
        end
      end
      StWdata: if (w_wbeat && r_beat == r_len) w_state_nxt = StWresp;
      StWresp: if (AXI_bready) w_state_nxt = StIdle;
      StRdata: if (w_pop && r_rlast) w_state_nxt = StIdle;
      default: w_state_nxt = StIdle;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= StIdle;
    else        r_state <= w_state_nxt;
  end

  // Transaction context, beat counters and sticky response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_wr    <= 1'b0;
      r_awready    <= 1'b0;
      r_arready    <= 1'b0;
      r_id         <= '0;
      r_len        <= '0;
      r_beat       <= '0;
      r_burst      <= BURST_FIXED;
      r_resp       <= RESP_OKAY;
      r_idx        <= '0;
      r_acc_err    <= 1'b0;
      r_issue_done <= 1'b0;
      r_pend       <= 1'b0;
      r_pend_last  <= 1'b0;
    end else begin
      r_awready   <= w_grant_wr;
      r_arready   <= w_grant_rd;
      r_pend      <= w_issue;
      r_pend_last <= w_issue && (r_beat == r_len);
      if (w_grant_wr) begin
        r_last_wr <= 1'b1;
        r_id      <= AXI_awid;
        r_len     <= AXI_awlen;
        r_burst   <= AXI_awburst;
        r_idx     <= idx_of(AXI_awaddr);
        r_resp    <= w_aw_chk;
        r_acc_err <= (w_aw_chk != RESP_OKAY);
        r_beat    <= '0;
      end else if (w_grant_rd) begin
        r_last_wr    <= 1'b0;
        r_id         <= AXI_arid;
        r_len        <= AXI_arlen;
        r_burst      <= AXI_arburst;
        r_idx        <= idx_of(AXI_araddr);
        r_resp       <= w_ar_chk;
        r_acc_err    <= (w_ar_chk != RESP_OKAY);
        r_beat       <= '0;
        r_issue_done <= 1'b0;
      end else if (w_wbeat) begin
        if (r_burst == BURST_INCR) r_idx <= r_idx + 1'b1;
        r_beat <= r_beat + 1'b1;
        // Protocol faults don't block the write but poison the response.
        if ((AXI_wid != r_id || AXI_wlast != (r_beat == r_len)) && r_resp == RESP_OKAY) begin
          r_resp <= RESP_SLVERR;
        end
      end else if (w_issue) begin
        if (r_burst == BURST_INCR) r_idx <= r_idx + 1'b1;
        r_beat       <= r_beat + 1'b1;
        r_issue_done <= (r_beat == r_len);
      end
    end
  end

  // Read output register with a one-entry skid for beats landing while rready is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rvalid    <= 1'b0;
      r_rlast     <= 1'b0;
      r_rdata     <= '0;
      r_skid_v    <= 1'b0;
      r_skid_last <= 1'b0;
      r_skid_data <= '0;
    end else if (!r_rvalid || w_pop) begin
      if (r_skid_v) begin
        r_rvalid    <= 1'b1;
        r_rdata     <= r_skid_data;
        r_rlast     <= r_skid_last;
        r_skid_v    <= r_pend;
        r_skid_data <= w_pend_data;
        r_skid_last <= r_pend_last;
      end else if (r_pend) begin
        r_rvalid <= 1'b1;
        r_rdata  <= w_pend_data;
        r_rlast  <= r_pend_last;
      end else begin
        r_rvalid <= 1'b0;
        r_rlast  <= 1'b0;
      end
    end else if (r_pend) begin
      r_skid_v    <= 1'b1;
      r_skid_data <= w_pend_data;
      r_skid_last <= r_pend_last;
    end
  end

  axi_hp_rsp_ram #(
    .MEM_AW (MEM_AW)
  ) u_ram (
    .clk     (clk),
    .i_en    (w_issue || (w_wbeat && !r_acc_err)),
    .i_we    (w_wbeat && !r_acc_err),
    .i_be    (AXI_wstrb),
    .i_addr  (r_idx),
    .i_wdata (AXI_wdata),
    .o_rdata (w_ram_rdata)
  );

  assign AXI_awready = r_awready;
  assign AXI_arready = r_arready;
  assign AXI_wready  = w_wready;
  assign AXI_bvalid  = (r_state == StWresp);
  assign AXI_bid     = r_id;
  assign AXI_bresp   = r_resp;
  assign AXI_rvalid  = r_rvalid;
  assign AXI_rdata   = r_rdata;
  assign AXI_rlast   = r_rlast;
  assign AXI_rid     = r_id;
  assign AXI_rresp   = r_resp;

endmodule

// File: tb/tb_axi_hp_responder.sv
// Scoreboard bench for axi_hp_responder: R/B expectations queued at drive time, checked on output.
module tb_axi_hp_responder;
  import axi_hp_pkg::*;

  localparam logic [31:0] BASE = 32'h1F00_0000;

  logic        clk, rst_n;
  logic [31:0] AXI_awaddr, AXI_araddr, AXI_wdata, AXI_rdata;
  logic [5:0]  AXI_awid, AXI_arid, AXI_wid, AXI_bid, AXI_rid;
  logic [3:0]  AXI_awlen, AXI_arlen, AXI_wstrb;
  logic [2:0]  AXI_awsize, AXI_arsize;
  logic [1:0]  AXI_awburst, AXI_arburst, AXI_bresp, AXI_rresp;
  logic        AXI_awvalid, AXI_awready, AXI_wlast, AXI_wvalid, AXI_wready;
  logic        AXI_bvalid, AXI_bready, AXI_arvalid, AXI_arready;
  logic        AXI_rlast, AXI_rvalid, AXI_rready;

  axi_hp_responder dut (
    .clk (clk), .rst_n (rst_n),
    .AXI_awaddr (AXI_awaddr), .AXI_awid (AXI_awid), .AXI_awlen (AXI_awlen),
    .AXI_awsize (AXI_awsize), .AXI_awburst (AXI_awburst), .AXI_awvalid (AXI_awvalid),
    .AXI_awready (AXI_awready),
    .AXI_wdata (AXI_wdata), .AXI_wstrb (AXI_wstrb), .AXI_wid (AXI_wid), .AXI_wlast (AXI_wlast),
    .AXI_wvalid (AXI_wvalid), .AXI_wready (AXI_wready),
    .AXI_bid (AXI_bid), .AXI_bresp (AXI_bresp), .AXI_bvalid (AXI_bvalid),
    .AXI_bready (AXI_bready),
    .AXI_araddr (AXI_araddr), .AXI_arid (AXI_arid), .AXI_arlen (AXI_arlen),
    .AXI_arsize (AXI_arsize), .AXI_arburst (AXI_arburst), .AXI_arvalid (AXI_arvalid),
    .AXI_arready (AXI_arready),
    .AXI_rdata (AXI_rdata), .AXI_rid (AXI_rid), .AXI_rresp (AXI_rresp), .AXI_rlast (AXI_rlast),
    .AXI_rvalid (AXI_rvalid), .AXI_rready (AXI_rready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic [1:0]  resp;
    logic        last;
    logic [5:0]  id;
  } r_exp_t;
  typedef struct {
    logic [5:0] id;
    logic [1:0] resp;
  } b_exp_t;

  r_exp_t      r_q[$];
  b_exp_t      b_q[$];
  bit          grant_log[$];
  logic [31:0] mdl [int];
  logic [31:0] wbuf [16];
  int          n_cmp = 0, n_err = 0, cyc = 0;
  int          ar_cyc, w_cyc, prev_pop, r_pops;
  bit          lat_pend, b_pend, have_prev, b2b_chk, hold_v;
  logic [31:0] hold_d;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor: handshakes sampled mid-cycle, scoreboards popped here.
  always @(negedge clk) begin
    if (!rst_n) begin
      lat_pend  = 1'b0;
      b_pend    = 1'b0;
      hold_v    = 1'b0;
      have_prev = 1'b0;
    end else begin
      if (AXI_awvalid && AXI_awready) grant_log.push_back(1'b1);
      if (AXI_arvalid && AXI_arready) begin
        grant_log.push_back(1'b0);
        ar_cyc    = cyc;
        lat_pend  = 1'b1;
        have_prev = 1'b0;
      end
      if (AXI_rvalid && lat_pend) begin
`ifndef AXI_RSP_STALL_EN
        check_eq("r_latency", cyc - ar_cyc, 2);
`endif
        lat_pend = 1'b0;
      end
      if (hold_v) begin
        check_eq("r_hold_valid", {31'd0, AXI_rvalid}, 1);
        check_eq("r_hold_data", AXI_rdata, hold_d);
      end
      hold_v = AXI_rvalid && !AXI_rready;
      hold_d = AXI_rdata;
      if (AXI_rvalid && AXI_rready) begin
        r_pops++;
        if (r_q.size() == 0) begin
          check_eq("r_unexpected", r_q.size(), 1);
        end else begin
          r_exp_t e;
          e = r_q.pop_front();
          check_eq("r_data", AXI_rdata, e.data);
          check_eq("r_resp", {30'd0, AXI_rresp}, {30'd0, e.resp});
          check_eq("r_last", {31'd0, AXI_rlast}, {31'd0, e.last});
          check_eq("r_id", {26'd0, AXI_rid}, {26'd0, e.id});
        end
`ifndef AXI_RSP_STALL_EN
        if (b2b_chk && have_prev) check_eq("r_b2b", cyc - prev_pop, 1);
`endif
        prev_pop  = cyc;
        have_prev = 1'b1;
      end
      if (AXI_wvalid && AXI_wready) begin
        w_cyc  = cyc;
        b_pend = 1'b1;
      end
      if (AXI_bvalid) begin
`ifndef AXI_RSP_STALL_EN
        if (b_pend) check_eq("b_latency", cyc - w_cyc, 1);
`endif
        b_pend = 1'b0;
        if (AXI_bready) begin
          if (b_q.size() == 0) begin
            check_eq("b_unexpected", b_q.size(), 1);
          end else begin
            b_exp_t e;
            e = b_q.pop_front();
            check_eq("b_resp", {30'd0, AXI_bresp}, {30'd0, e.resp});
            check_eq("b_id", {26'd0, AXI_bid}, {26'd0, e.id});
          end
        end
      end
    end
  end

  task automatic send_aw(input logic [31:0] a, input logic [5:0] id, input logic [3:0] len,
                         input logic [2:0] size, input logic [1:0] burst);
    int n = 0;
    AXI_awaddr = a; AXI_awid = id; AXI_awlen = len; AXI_awsize = size; AXI_awburst = burst;
    AXI_awvalid = 1'b1;
    do begin @(negedge clk); n++; end while (!AXI_awready && n < 100);
    check_eq("aw_handshake", {31'd0, AXI_awready}, 1);
    @(posedge clk); #1;
    AXI_awvalid = 1'b0;
  endtask

  task automatic send_ar(input logic [31:0] a, input logic [5:0] id, input logic [3:0] len,
                         input logic [2:0] size, input logic [1:0] burst);
    int n = 0;
    AXI_araddr = a; AXI_arid = id; AXI_arlen = len; AXI_arsize = size; AXI_arburst = burst;
    AXI_arvalid = 1'b1;
    do begin @(negedge clk); n++; end while (!AXI_arready && n < 100);
    check_eq("ar_handshake", {31'd0, AXI_arready}, 1);
    @(posedge clk); #1;
    AXI_arvalid = 1'b0;
  endtask

  task automatic send_w(input logic [31:0] d, input logic [3:0] strb, input logic [5:0] id,
                        input logic last);
    int n = 0;
    AXI_wdata = d; AXI_wstrb = strb; AXI_wid = id; AXI_wlast = last; AXI_wvalid = 1'b1;
    do begin @(negedge clk); n++; end while (!AXI_wready && n < 100);
    check_eq("w_handshake", {31'd0, AXI_wready}, 1);
    @(posedge clk); #1;
    AXI_wvalid = 1'b0;
  endtask

  task automatic do_write(input logic [31:0] a, input logic [5:0] id, input logic [3:0] len,
                          input logic [1:0] burst, input logic [3:0] strb,
                          input logic [1:0] exp_resp, input bit upd, input bit bad_last);
    b_exp_t e;
    int     n = 0;
    e.id = id; e.resp = exp_resp;
    b_q.push_back(e);
    send_aw(a, id, len, 3'b010, burst);
    for (int i = 0; i <= int'(len); i++) begin
      int          idx;
      logic [31:0] old;
      idx = int'((a - BASE) >> 2) + ((burst == BURST_INCR) ? i : 0);
      if (upd) begin
        old = mdl.exists(idx) ? mdl[idx] : 32'h0;
        for (int b = 0; b < 4; b++) if (strb[b]) old[8*b +: 8] = wbuf[i][8*b +: 8];
        mdl[idx] = old;
      end
      send_w(wbuf[i], strb, id, bad_last ? 1'b0 : (i == int'(len)));
    end
    while (b_q.size() != 0 && n < 100) begin @(posedge clk); #1; n++; end
    check_eq("b_drain", b_q.size(), 0);
  endtask

  task automatic do_read(input logic [31:0] a, input logic [5:0] id, input logic [3:0] len,
                         input logic [2:0] size, input logic [1:0] exp_resp, input bit tog);
    int n = 0;
    for (int i = 0; i <= int'(len); i++) begin
      r_exp_t e;
      int     idx;
      idx    = int'((a - BASE) >> 2) + i;
      e.data = (exp_resp == RESP_OKAY && mdl.exists(idx)) ? mdl[idx] : 32'h0;
      e.resp = exp_resp;
      e.last = (i == int'(len));
      e.id   = id;
      r_q.push_back(e);
    end
    send_ar(a, id, len, size, BURST_INCR);
    while (r_q.size() != 0 && n < 300) begin
      @(posedge clk); #1;
      if (tog) AXI_rready = ~AXI_rready;
      n++;
    end
    AXI_rready = 1'b1;
    check_eq("r_drain", r_q.size(), 0);
  endtask

  initial begin
    bit exp_g [4];
    exp_g = '{1'b1, 1'b0, 1'b1, 1'b0};
    rst_n = 1'b0;
    AXI_awaddr = '0; AXI_awid = '0; AXI_awlen = '0; AXI_awsize = '0; AXI_awburst = '0;
    AXI_awvalid = 1'b0; AXI_wdata = '0; AXI_wstrb = '0; AXI_wid = '0; AXI_wlast = 1'b0;
    AXI_wvalid = 1'b0; AXI_bready = 1'b1; AXI_araddr = '0; AXI_arid = '0; AXI_arlen = '0;
    AXI_arsize = '0; AXI_arburst = '0; AXI_arvalid = 1'b0; AXI_rready = 1'b1;
    b2b_chk = 1'b0; r_pops = 0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_awready", {31'd0, AXI_awready}, 0);
    check_eq("rst_arready", {31'd0, AXI_arready}, 0);
    check_eq("rst_wready", {31'd0, AXI_wready}, 0);
    check_eq("rst_bvalid", {31'd0, AXI_bvalid}, 0);
    check_eq("rst_rvalid", {31'd0, AXI_rvalid}, 0);
    check_eq("rst_bresp", {30'd0, AXI_bresp}, 0);
    check_eq("rst_rresp", {30'd0, AXI_rresp}, 0);
    check_eq("rst_ids", {20'd0, AXI_bid, AXI_rid}, 0);
    check_eq("rst_rdata", AXI_rdata, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // 1: INCR write then back-to-back INCR read
    for (int i = 0; i < 4; i++) wbuf[i] = 32'(i + 1);
    do_write(BASE, 6'h0A, 4'd3, BURST_INCR, 4'hF, RESP_OKAY, 1'b1, 1'b0);
    b2b_chk = 1'b1;
    do_read(BASE, 6'h0B, 4'd3, 3'b010, RESP_OKAY, 1'b0);
    b2b_chk = 1'b0;

    // 2: FIXED overwrite, partial strobes, wlast on the wrong beat
    wbuf[0] = 32'hAAAA_AAAA; wbuf[1] = 32'hBBBB_BBBB;
    do_write(BASE + 32'h8, 6'h01, 4'd1, BURST_FIXED, 4'hF, RESP_OKAY, 1'b1, 1'b0);
    do_read(BASE + 32'h8, 6'h02, 4'd0, 3'b010, RESP_OKAY, 1'b0);
    wbuf[0] = 32'h0;
    do_write(BASE + 32'hC, 6'h03, 4'd0, BURST_INCR, 4'hF, RESP_OKAY, 1'b1, 1'b0);
    wbuf[0] = 32'hFFFF_FFFF;
    do_write(BASE + 32'hC, 6'h03, 4'd0, BURST_INCR, 4'b0011, RESP_OKAY, 1'b1, 1'b0);
    do_read(BASE + 32'hC, 6'h04, 4'd0, 3'b010, RESP_OKAY, 1'b0);
    check_eq("partial_model", mdl[3], 32'h0000_FFFF);
    wbuf[0] = 32'h1111_0011; wbuf[1] = 32'h2222_0022;
    do_write(BASE + 32'h20, 6'h05, 4'd1, BURST_INCR, 4'hF, RESP_SLVERR, 1'b1, 1'b1);
    do_read(BASE + 32'h20, 6'h06, 4'd1, 3'b010, RESP_OKAY, 1'b0);

    // 3: burst running off the top of the region, bad arsize
    wbuf[0] = 32'hCAFE_0001;
    do_write(BASE + 32'h3FFC, 6'h07, 4'd0, BURST_INCR, 4'hF, RESP_OKAY, 1'b1, 1'b0);
    wbuf[0] = 32'hDEAD_0000; wbuf[1] = 32'hDEAD_0001;
    do_write(BASE + 32'h3FFC, 6'h08, 4'd1, BURST_INCR, 4'hF, RESP_DECERR, 1'b0, 1'b0);
    do_read(BASE + 32'h3FFC, 6'h09, 4'd0, 3'b010, RESP_OKAY, 1'b0);
    do_read(BASE, 6'h0C, 4'd1, 3'b001, RESP_SLVERR, 1'b0);

    // 4: contested aw/ar twice after a read -> W, R, W, R
    grant_log.delete();
    for (int i = 0; i < 4; i++) wbuf[i] = 32'h4000 + 32'(i);
    for (int k = 0; k < 2; k++) begin
      fork
        do_write(BASE + 32'h40, 6'h10, 4'd3, BURST_INCR, 4'hF, RESP_OKAY, 1'b1, 1'b0);
        do_read(BASE, 6'h11, 4'd3, 3'b010, RESP_OKAY, 1'b0);
      join
    end
    check_eq("grant_count", grant_log.size(), 4);
    for (int i = 0; i < 4 && i < grant_log.size(); i++) begin
      check_eq("grant_order", {31'd0, grant_log[i]}, {31'd0, exp_g[i]});
    end

    // 5: 16-beat read with rready toggling
    for (int i = 0; i < 16; i++) wbuf[i] = 32'h5A00_0000 + 32'(i * 7);
    do_write(BASE + 32'h100, 6'h12, 4'd15, BURST_INCR, 4'hF, RESP_OKAY, 1'b1, 1'b0);
    r_pops = 0;
    do_read(BASE + 32'h100, 6'h13, 4'd15, 3'b010, RESP_OKAY, 1'b1);
    check_eq("r_beats_16", r_pops, 16);

    // 6: reset in the middle of a write burst
    for (int i = 0; i < 8; i++) wbuf[i] = 32'h0600 + 32'(i);
    send_aw(BASE + 32'h200, 6'h14, 4'd7, 3'b010, BURST_INCR);
    for (int i = 0; i < 3; i++) begin
      mdl[128 + i] = wbuf[i];
      send_w(wbuf[i], 4'hF, 6'h14, 1'b0);
    end
    rst_n = 1'b0;
    #2;
    check_eq("mid_rst_wready", {31'd0, AXI_wready}, 0);
    check_eq("mid_rst_bvalid", {31'd0, AXI_bvalid}, 0);
    check_eq("mid_rst_rvalid", {31'd0, AXI_rvalid}, 0);
    check_eq("mid_rst_ready", {30'd0, AXI_awready, AXI_arready}, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    do_read(BASE + 32'h200, 6'h15, 4'd2, 3'b010, RESP_OKAY, 1'b0);
    repeat (5) @(posedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
